timer_ctrl: RTL

Synchronous controller for the TIMA/TMA/TAC timer registers (FF05–FF07), driven by the free-running divider taps from the clocks/reset page. It selects a divider tap per TAC, detects its falling edge, increments TIMA, and sequences the overflow → reload → interrupt handshake. It occupies the FF04–FF07 decode window beside the divider and raises the timer interrupt request toward the interrupt controller.

---
 rtl/timer_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// TIMA/TMA/TAC timer: divider tap select, falling-edge tick, overflow -> reload -> interrupt.
// Optional macro TIMER_TAC_GLITCH_EN: TAC writes can produce a tick, as the original hardware does.
module timer_ctrl (
    input  logic       boga1mhz,
    input  logic       nreset2,
    input  logic       ff04_ff07,
    input  logic [1:0] a,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic       tap_4096hz,
    input  logic       tap_262144hz,
    input  logic       tap_65536hz,
    input  logic       tap_16384hz,
    output logic       int_timer
);

    logic [7:0] tima, tma;
    logic [2:0] tac;
    logic       sig_q, reload_pend;

    logic       tap_sel, sig, tick;
    logic       wr_tima, wr_tma, wr_tac;
    logic [8:0] tima_inc;
    logic [7:0] tima_nxt, tma_nxt;
    logic [2:0] tac_nxt;
    logic       pend_nxt, int_nxt;

    assign wr_tima = ff04_ff07 & cpu_wr & (a == 2'b01);
    assign wr_tma  = ff04_ff07 & cpu_wr & (a == 2'b10);
    assign wr_tac  = ff04_ff07 & cpu_wr & (a == 2'b11);

    always_comb begin
        case (tac[1:0])
            2'b00:   tap_sel = tap_4096hz;
            2'b01:   tap_sel = tap_262144hz;
            2'b10:   tap_sel = tap_65536hz;
            default: tap_sel = tap_16384hz;
        endcase
    end

    assign sig = tac[2] & tap_sel;

`ifdef TIMER_TAC_GLITCH_EN
    assign tick = sig_q & ~sig;
`else
    // Previous TAC value; a falling edge only counts when TAC did not change under it.
    logic [2:0] tac_q;
    assign tick = sig_q & ~sig & (tac_q == tac);
`endif

    assign tima_inc = {1'b0, tima} + 9'd1;

    always_comb begin
        tma_nxt  = wr_tma ? d_in : tma;
        tac_nxt  = wr_tac ? d_in[2:0] : tac;
        tima_nxt = tima;
        pend_nxt = reload_pend;
        int_nxt  = 1'b0;
        if (int_timer) begin
            // Reload cycle: TIMA follows TMA (including a same-cycle TMA write); TIMA writes and ticks are lost.
            tima_nxt = tma_nxt;
        end else if (reload_pend) begin
            pend_nxt = 1'b0;
            if (wr_tima) begin
                tima_nxt = d_in;
            end else begin
                tima_nxt = tma_nxt;
                int_nxt  = 1'b1;
            end
        end else if (wr_tima) begin
            tima_nxt = d_in;
        end else if (tick) begin
            tima_nxt = tima_inc[7:0];
            pend_nxt = tima_inc[8];
        end
    end

    always_ff @(posedge boga1mhz) begin
        if (!nreset2) begin
            tima        <= 8'h00;
            tma         <= 8'h00;
            tac         <= 3'b000;
            sig_q       <= 1'b0;
            reload_pend <= 1'b0;
            int_timer   <= 1'b0;
`ifndef TIMER_TAC_GLITCH_EN
            tac_q       <= 3'b000;
`endif
        end else begin
            tima        <= tima_nxt;
            tma         <= tma_nxt;
            tac         <= tac_nxt;
            sig_q       <= sig;
            reload_pend <= pend_nxt;
            int_timer   <= int_nxt;
`ifndef TIMER_TAC_GLITCH_EN
            tac_q       <= tac;
`endif
        end
    end

    // FF04 belongs to the divider, so this block never drives it.
    always_comb begin
        d_oe  = 1'b0;
        d_out = 8'h00;
        if (ff04_ff07 && cpu_rd && (a != 2'b00)) begin
            d_oe = 1'b1;
            case (a)
                2'b01:   d_out = tima;
                2'b10:   d_out = tma;
                default: d_out = {5'b11111, tac};
            endcase
        end
    end

endmodule
